vc_writeback_engine: RTL and testbench
======================================

# vc_writeback_engine

Read-side companion of the victim cache data array: drives the array's writeback index, captures the selected line and its tag, and writes the line to physical memory over the pmem handshake. It handles two kinds of request. A single-entry eviction writes back one dirty victim line. A flush drains every dirty entry, lowest index first. The block sits between the victim cache controller, which owns the dirty and tag bits, and the physical-memory arbiter.

## Interface
- `width`, 128, line width in bits (data path to the array and pmem)
- `tagw`, 12, line-address tag width; `pmem_address = {tag, 4'b0}`

- `clk`  in  1  clock, all state updates on the rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `evict_req`  in  1  level request to write back entry `evict_index`; held until `evict_done`
- `evict_index`  in  3  entry to evict; sampled with `evict_req`
- `flush_req`  in  1  level request to drain all dirty entries; held until `flush_done`
- `dirty_in`  in  8  per-entry dirty bits from the controller
- `wdataout`  in  width  array line at `wb_index_out` (combinational from the array)
- `wtag_in`  in  tagw  tag-array entry at `wb_index_out` (combinational)
- `wb_index_out`  out  3  array writeback index
- `pmem_write`  out  1  memory write strobe
- `pmem_address`  out  16  line address
- `pmem_wdata`  out  width  line data
- `pmem_resp`  in  1  memory acknowledge, one cycle
- `clear_dirty`  out  1  one-cycle pulse: clear the dirty bit of `clear_index`
- `clear_index`  out  3  entry whose dirty bit is cleared
- `evict_done`  out  1  one-cycle acknowledge of `evict_req`
- `flush_done`  out  1  one-cycle acknowledge of `flush_req`
- `busy`  out  1  high in every state except IDLE

## Operation
- The block has five states: IDLE, SCAN, LOAD, WRITE, DONE. The state register, the captured index, tag and data, the mode flag, and all outputs are registers.
- **IDLE transitions:**
  - If `evict_req` is high and `dirty_in[evict_index]` is set: latch the index, set mode to EVICT, go to LOAD.
  - If `evict_req` is high and the entry is clean: pulse `evict_done` next cycle and stay in IDLE. No pmem traffic.
  - Otherwise, if `flush_req` is high: set mode to FLUSH, go to SCAN.
  - `evict_req` has priority over `flush_req` when both are high.
- **SCAN:**
  - Priority-encode the current `dirty_in` and pick the lowest set index.
  - If a bit is set: latch that index and go to LOAD.
  - If no bit is set: pulse `flush_done` next cycle and return to IDLE.
- **LOAD:**
  - `wb_index_out` equals the latched index.
  - At the end of the cycle, capture `wdataout` into `pmem_wdata` and `{wtag_in, 4'b0}` into `pmem_address`. Go to WRITE.
- **WRITE:**
  - `pmem_write` is high. `pmem_address` and `pmem_wdata` are held stable.
  - When `pmem_resp` arrives, go to DONE.
- **DONE:**
  - `clear_dirty` pulses with `clear_index` set to the latched index.
  - In EVICT mode: pulse `evict_done` in the same cycle and go to IDLE.
  - In FLUSH mode: go to SCAN.
- Only IDLE samples `evict_req` and `flush_req`. Requests raised while `busy` is high wait until the block returns to IDLE.
- SCAN reads `dirty_in` live. Bits cleared or set by the controller between entries are honoured.
- `wb_index_out` holds the latched index from LOAD through DONE, and in IDLE it keeps its last value.

## Timing
- **Reset:** asynchronous assertion forces IDLE. The following outputs go to 0: `wb_index_out`, `pmem_write`, `pmem_address`, `pmem_wdata`, `clear_dirty`, `clear_index`, `evict_done`, `flush_done`, `busy`.
  - Reset during WRITE drops `pmem_write` immediately. No `clear_dirty` or done pulse follows.
  - Reset during a flush aborts it. The requester re-issues the request.
- **Dirty eviction latency:** `evict_req` is sampled in cycle T.
  - T+1: LOAD, `busy`=1.
  - T+2: `pmem_write` goes high.
  - With `pmem_resp` in cycle R: DONE in R+1, where `clear_dirty` and `evict_done` are high. `pmem_write` is low in R+1.
  - Minimum total with a zero-wait response: `pmem_resp` at T+2, done at T+3.
- **Clean eviction:** `evict_done` pulses at T+1 and `busy` stays 0.
- **Flush:** each dirty entry costs SCAN + LOAD + WRITE (at least one cycle) + DONE, so 4 cycles minimum per entry. The final SCAN is followed by `flush_done` one cycle later.
  - With no dirty entries: `flush_req` at T, SCAN at T+1, `flush_done` at T+2.
- `pmem_resp` outside WRITE is ignored.

## Test plan
- **Dirty evict:** `dirty_in`=8'b0010_0000, `evict_req` with index 5, `wtag_in`=12'hABC, resp after 3 wait cycles. Expect:
  - `pmem_address`=16'hABC0 and `pmem_wdata` equal to array entry 5.
  - `pmem_write` high for 4 cycles.
  - `clear_dirty` with `clear_index`=5 and `evict_done` together in one cycle.
- **Clean evict:** `dirty_in`=0, `evict_req` index 2. Expect `evict_done` the next cycle, `pmem_write` never high, `busy` stays 0.
- **Flush:** `dirty_in`=8'b1000_1001, zero-wait resp, with the controller clearing bits on `clear_dirty`. Expect:
  - Writebacks for indices 0, 3, 7 in that order.
  - `flush_done` exactly once, 14 cycles after the request cycle.
- **Simultaneous requests:** `evict_req` (index 4, dirty) and `flush_req` raised in the same cycle. Expect:
  - The eviction of 4 completes first.
  - The flush then starts from IDLE and writes back the remaining dirty entries.
- **Reset mid-write:** `reset_n` low while in WRITE. Expect:
  - All outputs drop to 0 asynchronously.
  - No `clear_dirty` pulse.
  - After release, the block is in IDLE and accepts a new eviction normally.

Source files
------------

// File: rtl/vc_writeback_engine.sv
// Victim cache writeback engine: reads dirty lines out of the data array and
// writes them to physical memory, either one victim or every dirty entry.
module vc_writeback_engine #(
    parameter int width = 128,
    parameter int tagw  = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             evict_req,
    input  logic [2:0]       evict_index,
    input  logic             flush_req,
    input  logic [7:0]       dirty_in,
    input  logic [width-1:0] wdataout,
    input  logic [tagw-1:0]  wtag_in,
    output logic [2:0]       wb_index_out,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [width-1:0] pmem_wdata,
    input  logic             pmem_resp,
    output logic             clear_dirty,
    output logic [2:0]       clear_index,
    output logic             evict_done,
    output logic             flush_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOAD,
        WRITE,
        DONE
    } state_t;

    typedef enum logic {
        MODE_EVICT,
        MODE_FLUSH
    } mode_t;

    state_t     state, next_state;
    mode_t      mode, next_mode;
    logic [2:0] idx_q, next_idx;
    logic [2:0] scan_idx;
    logic       scan_hit;
    logic       evict_accept;
    logic       flush_accept;
    logic       clean_ack;
    logic       flush_finish;

    assign wb_index_out = idx_q;

    // Lowest-numbered dirty entry; the descending loop lets the smallest index win.
    always_comb begin
        scan_idx = 3'd0;
        scan_hit = |dirty_in;
        for (int i = 7; i >= 0; i--) begin
            if (dirty_in[i]) begin
                scan_idx = 3'(i);
            end
        end
    end

    // Requests stay high through the cycle carrying their done pulse, so a
    // request seen while its own acknowledge is up is the old one and is ignored.
    always_comb begin
        next_state   = state;
        next_mode    = mode;
        next_idx     = idx_q;
        clean_ack    = 1'b0;
        flush_finish = 1'b0;
        evict_accept = evict_req && !evict_done;
        flush_accept = flush_req && !flush_done;

        case (state)
            IDLE: begin
                if (evict_accept) begin
                    if (dirty_in[evict_index]) begin
                        next_idx   = evict_index;
                        next_mode  = MODE_EVICT;
                        next_state = LOAD;
                    end else begin
                        clean_ack = 1'b1;
                    end
                end else if (flush_accept) begin
                    next_mode  = MODE_FLUSH;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    next_idx   = scan_idx;
                    next_state = LOAD;
                end else begin
                    flush_finish = 1'b1;
                    next_state   = IDLE;
                end
            end
            LOAD: begin
                next_state = WRITE;
            end
            WRITE: begin
                if (pmem_resp) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = (mode == MODE_EVICT) ? IDLE : SCAN;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // All outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mode         <= MODE_EVICT;
            idx_q        <= 3'd0;
            pmem_write   <= 1'b0;
            pmem_address <= 16'd0;
            pmem_wdata   <= '0;
            clear_dirty  <= 1'b0;
            clear_index  <= 3'd0;
            evict_done   <= 1'b0;
            flush_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state       <= next_state;
            mode        <= next_mode;
            idx_q       <= next_idx;
            busy        <= (next_state != IDLE);
            pmem_write  <= (next_state == WRITE);
            clear_dirty <= (next_state == DONE);
            evict_done  <= clean_ack || ((next_state == DONE) && (mode == MODE_EVICT));
            flush_done  <= flush_finish;
            if (next_state == DONE) begin
                clear_index <= idx_q;
            end
            if (state == LOAD) begin
                pmem_address <= 16'({wtag_in, 4'b0000});
                pmem_wdata   <= wdataout;
            end
        end
    end

endmodule

// File: tb/tb_vc_writeback_engine.sv
// Bench for vc_writeback_engine: array/tag/controller/pmem models around the DUT
// with a scoreboard of expected writebacks derived from the dirty mask.
module tb_vc_writeback_engine;

    localparam int W  = 128;
    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          evict_req;
    logic [2:0]    evict_index;
    logic          flush_req;
    logic [7:0]    dirty_in;
    logic [W-1:0]  wdataout;
    logic [TW-1:0] wtag_in;
    logic [2:0]    wb_index_out;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [W-1:0]  pmem_wdata;
    logic          pmem_resp;
    logic          clear_dirty;
    logic [2:0]    clear_index;
    logic          evict_done;
    logic          flush_done;
    logic          busy;

    logic [W-1:0]  arr  [8];
    logic [TW-1:0] tags [8];

    always #5 clk = ~clk;

    assign wdataout = arr[wb_index_out];
    assign wtag_in  = tags[wb_index_out];

    vc_writeback_engine #(.width(W), .tagw(TW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .evict_req    (evict_req),
        .evict_index  (evict_index),
        .flush_req    (flush_req),
        .dirty_in     (dirty_in),
        .wdataout     (wdataout),
        .wtag_in      (wtag_in),
        .wb_index_out (wb_index_out),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .clear_dirty  (clear_dirty),
        .clear_index  (clear_index),
        .evict_done   (evict_done),
        .flush_done   (flush_done),
        .busy         (busy)
    );

    typedef struct {
        logic [15:0]  addr;
        logic [W-1:0] data;
        logic [2:0]   idx;
        bit           flush;
    } wr_t;

    typedef struct {
        bit         is_flush;
        logic [2:0] idx;
        logic [7:0] dirty;
        int         rwait;
        int         exp_writes;
        int         exp_latency;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           resp_wait = 0;
    int           write_len = 0;
    int           n_writes = 0;
    int           n_clears = 0;
    int           n_evict_done = 0;
    int           n_flush_done = 0;
    int           evict_done_cyc = 0;
    int           flush_done_cyc = 0;
    bit           noise = 1'b0;
    bit           drop_evict = 1'b0;
    bit           drop_flush = 1'b0;
    bit           prev_write = 1'b0;
    bit           saw_busy = 1'b0;
    logic [15:0]  last_addr = '0;
    logic [W-1:0] last_data = '0;
    wr_t          cur;
    wr_t          exp_q [$];
    vec_t         table_v [8];

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input int i, input bit fl);
        wr_t r;
        r.addr  = {tags[i], 4'b0000};
        r.data  = arr[i];
        r.idx   = 3'(i);
        r.flush = fl;
        return r;
    endfunction

    task automatic fillArrays();
        for (int i = 0; i < 8; i++) begin
            arr[i]  = {$urandom, $urandom, $urandom, $urandom};
            tags[i] = TW'($urandom);
        end
    endtask

    // One clock cycle: observe outputs at the falling edge, then play the
    // roles of requester, controller and memory for the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (drop_evict) begin
            evict_req  = 1'b0;
            drop_evict = 1'b0;
        end
        if (drop_flush) begin
            flush_req  = 1'b0;
            drop_flush = 1'b0;
        end
        saw_busy = saw_busy | busy;
        if (evict_done) begin
            n_evict_done++;
            evict_done_cyc = cyc;
            drop_evict     = 1'b1;
        end
        if (flush_done) begin
            n_flush_done++;
            flush_done_cyc = cyc;
            drop_flush     = 1'b1;
        end
        if (pmem_write && !prev_write) begin
            n_writes++;
            write_len = 0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h, required no write", pmem_address);
            end else begin
                cur = exp_q.pop_front();
                checkOutput("wb_addr", pmem_address, cur.addr);
                checkOutput("wb_data", pmem_wdata, cur.data);
            end
            last_addr = pmem_address;
            last_data = pmem_wdata;
        end else if (pmem_write) begin
            checkOutput("hold_addr", pmem_address, last_addr);
            checkOutput("hold_data", pmem_wdata, last_data);
        end
        if (pmem_write) begin
            write_len++;
            pmem_resp = (write_len == resp_wait + 1);
        end else begin
            if (prev_write) checkOutput("write_len", write_len, resp_wait + 1);
            pmem_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        prev_write = pmem_write;
        if (clear_dirty) begin
            n_clears++;
            checkOutput("clear_index", clear_index, cur.idx);
            checkOutput("done_with_clear", evict_done, !cur.flush);
            dirty_in[clear_index] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int         t0, w0, e0, f0;
        bit         got;
        logic [7:0] exp_final;
        resp_wait = v.rwait;
        dirty_in  = v.dirty;
        exp_final = v.dirty;
        exp_q.delete();
        if (v.is_flush) begin
            for (int i = 0; i < 8; i++) if (v.dirty[i]) exp_q.push_back(mk(i, 1'b1));
            exp_final = 8'd0;
        end else if (v.dirty[v.idx]) begin
            exp_q.push_back(mk(int'(v.idx), 1'b0));
            exp_final[v.idx] = 1'b0;
        end
        w0 = n_writes;
        e0 = n_evict_done;
        f0 = n_flush_done;
        step();
        saw_busy = 1'b0;
        if (v.is_flush) begin
            flush_req = 1'b1;
        end else begin
            evict_req   = 1'b1;
            evict_index = v.idx;
        end
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = v.is_flush ? (n_flush_done != f0) : (n_evict_done != e0);
        end
        checkOutput({tag, "_done_seen"}, got, 1);
        if (got) checkOutput({tag, "_latency"}, (v.is_flush ? flush_done_cyc : evict_done_cyc) - t0, v.exp_latency);
        repeat (4) step();
        checkOutput({tag, "_writes"}, n_writes - w0, v.exp_writes);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_done_once"}, v.is_flush ? (n_flush_done - f0) : (n_evict_done - e0), 1);
        checkOutput({tag, "_dirty_final"}, dirty_in, exp_final);
        checkOutput({tag, "_busy_seen"}, saw_busy, (v.is_flush || v.exp_writes > 0));
        checkOutput({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int   t0, w0, c0, e0;
        bit   got;
        vec_t v;

        table_v[0] = '{1'b0, 3'd5, 8'b0010_0000, 3, 1, 6};
        table_v[1] = '{1'b0, 3'd2, 8'b0000_0000, 0, 0, 1};
        table_v[2] = '{1'b1, 3'd0, 8'b1000_1001, 0, 3, 14};
        table_v[3] = '{1'b1, 3'd0, 8'b0000_0000, 0, 0, 2};
        table_v[4] = '{1'b0, 3'd0, 8'b0000_0001, 0, 1, 3};
        table_v[5] = '{1'b0, 3'd7, 8'b0111_1111, 2, 0, 1};
        table_v[6] = '{1'b1, 3'd0, 8'b1111_1111, 1, 8, 42};
        table_v[7] = '{1'b0, 3'd3, 8'b1111_1111, 2, 1, 5};

        fillArrays();
        tags[5]     = 12'hABC;
        reset_n     = 1'b0;
        evict_req   = 1'b0;
        evict_index = 3'd0;
        flush_req   = 1'b0;
        dirty_in    = 8'd0;
        pmem_resp   = 1'b0;
        cur         = mk(0, 1'b0);

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pmem_write", pmem_write, 0);
        checkOutput("rst_addr", pmem_address, 0);
        checkOutput("rst_wdata", pmem_wdata, 0);
        checkOutput("rst_wb_index", wb_index_out, 0);
        checkOutput("rst_clear", clear_dirty, 0);
        checkOutput("rst_evict_done", evict_done, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(table_v[k], $sformatf("vec%0d", k));
            if (k == 0) begin
                checkOutput("abc_addr", last_addr, 16'hABC0);
                checkOutput("abc_data", last_data, arr[5]);
            end
        end

        // Eviction and flush raised together: the eviction goes first.
        resp_wait = 0;
        dirty_in  = 8'b0101_0010;
        exp_q.delete();
        exp_q.push_back(mk(4, 1'b0));
        exp_q.push_back(mk(1, 1'b1));
        exp_q.push_back(mk(6, 1'b1));
        w0 = n_writes;
        step();
        evict_req   = 1'b1;
        evict_index = 3'd4;
        flush_req   = 1'b1;
        t0  = cyc;
        c0  = n_flush_done;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = (n_flush_done != c0);
        end
        checkOutput("both_done_seen", got, 1);
        checkOutput("both_evict_lat", evict_done_cyc - t0, 3);
        checkOutput("both_flush_lat", flush_done_cyc - t0, 14);
        repeat (4) step();
        checkOutput("both_writes", n_writes - w0, 3);
        checkOutput("both_pending", exp_q.size(), 0);
        checkOutput("both_dirty", dirty_in, 8'd0);

        // Reset while the memory is still holding off its acknowledge.
        resp_wait = 1000;
        dirty_in  = 8'b0000_0100;
        exp_q.delete();
        exp_q.push_back(mk(2, 1'b0));
        step();
        evict_req   = 1'b1;
        evict_index = 3'd2;
        repeat (4) step();
        checkOutput("pre_reset_write", pmem_write, 1);
        #2;
        reset_n   = 1'b0;
        evict_req = 1'b0;
        #1;
        checkOutput("mid_rst_write", pmem_write, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_addr", pmem_address, 0);
        checkOutput("mid_rst_wdata", pmem_wdata, 0);
        checkOutput("mid_rst_index", wb_index_out, 0);
        checkOutput("mid_rst_clear_index", clear_index, 0);
        prev_write = 1'b0;
        c0 = n_clears;
        e0 = n_evict_done;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();
        checkOutput("mid_rst_no_clear", n_clears - c0, 0);
        checkOutput("mid_rst_no_done", n_evict_done - e0, 0);
        applyStimulus('{1'b0, 3'd2, 8'b0000_0100, 0, 1, 3}, "post_reset");

        // Random requests checked against the rule-level model.
        noise = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k % 8 == 0) fillArrays();
            v.is_flush    = ($urandom_range(0, 3) == 0);
            v.idx         = 3'($urandom_range(0, 7));
            v.dirty       = 8'($urandom);
            v.rwait       = $urandom_range(0, 3);
            v.exp_writes  = v.is_flush ? $countones(v.dirty) : int'(v.dirty[v.idx]);
            v.exp_latency = v.is_flush ? 2 + v.exp_writes * (4 + v.rwait)
                                       : (v.dirty[v.idx] ? 3 + v.rwait : 1);
            applyStimulus(v, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
